m_frame_serializer: RTL and testbench



---
 rtl/m_frame_serializer.sv | 250 +++++++++++++++++++++++++
 tb/tb_m_frame_serializer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/m_frame_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | m_frame_serializer                                                       |
// | Double-buffered frame memory to serial telemetry line: each word becomes |
// | 2*DATA_W bit-doubled or Manchester symbols with phrase/group/cycle sync   |
// | markers. Optional BCD seconds counter when M_SEC_COUNTER_EN is defined.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module m_frame_serializer #(
    parameter int DATA_W      = 12,
    parameter int ADDR_W      = 10,
    parameter int BIT_DIV     = 4,
    parameter int WRD_PER_PHR = 8,
    parameter int PHR_PER_GRP = 128,
    parameter int GRP_PER_CCL = 32,
    parameter int CCL_PER_FRM = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [DATA_W-1:0]                iData,
    input  logic                             iMode,
    output logic                             oRdEn,
    output logic [ADDR_W-1:0]                oAddr,
    output logic                             oSwitch,
    output logic                             oSerial,
    output logic [DATA_W-1:0]                oParallel,
    output logic                             oValid,
    output logic [1:0]                       oMarker,
    output logic [$clog2(PHR_PER_GRP)-1:0]   oPhr,
    output logic [$clog2(GRP_PER_CCL)-1:0]   oGrp,
    output logic [15:0]                      oSec
);

    localparam int c_NSYM  = 2 * DATA_W;
    localparam int c_SYM_W = $clog2(c_NSYM);
    localparam int c_PH_W  = $clog2(BIT_DIV);
    localparam int c_WRD_W = (WRD_PER_PHR > 1) ? $clog2(WRD_PER_PHR) : 1;
    localparam int c_PHR_W = $clog2(PHR_PER_GRP);
    localparam int c_GRP_W = $clog2(GRP_PER_CCL);
    localparam int c_CCL_W = (CCL_PER_FRM > 1) ? $clog2(CCL_PER_FRM) : 1;

    logic [c_PH_W-1:0]  phase_q, phase_d;
    logic [c_SYM_W-1:0] sym_q, sym_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic               mode_q, mode_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [c_WRD_W-1:0] wrd_q, wrd_d;
    logic [c_PHR_W-1:0] phr_q, phr_d;
    logic [c_GRP_W-1:0] grp_q, grp_d;
    logic [c_CCL_W-1:0] ccl_q, ccl_d;

    logic               serial_q, serial_d;
    logic               valid_q, valid_d;
    logic [DATA_W-1:0]  par_q, par_d;
    logic [1:0]         mark_q, mark_d;
    logic [c_PHR_W-1:0] phr_o_q, phr_o_d;
    logic [c_GRP_W-1:0] grp_o_q, grp_o_d;
    logic               rden_q, rden_d;
    logic [ADDR_W-1:0]  oaddr_q, oaddr_d;
    logic               switch_q, switch_d;

    logic       w_sym_start, w_phase_end, w_last_sym, w_load, w_rd;
    logic       w_wrd_wrap, w_phr_wrap, w_grp_wrap, w_ccl_wrap_pos;
    logic       w_grp_last, w_sync_a, w_sync_b, w_sync_c, w_frame_sync;
    logic [1:0] w_marker;
    logic       w_sym_bit, w_serial;

    assign w_sym_start = (phase_q == '0);
    assign w_phase_end = (phase_q == c_PH_W'(BIT_DIV - 1));
    assign w_last_sym  = (sym_q == c_SYM_W'(c_NSYM - 1));
    assign w_load      = w_phase_end && w_last_sym;
    assign w_rd        = w_sym_start && w_last_sym;

    assign w_wrd_wrap     = (wrd_q == c_WRD_W'(WRD_PER_PHR - 1));
    assign w_phr_wrap     = (phr_q == c_PHR_W'(PHR_PER_GRP - 1));
    assign w_grp_wrap     = (grp_q == c_GRP_W'(GRP_PER_CCL - 1));
    assign w_ccl_wrap_pos = (ccl_q == c_CCL_W'(CCL_PER_FRM - 1));

    // Frame sync pattern: the last group of a cycle uses a different phrase set
    assign w_grp_last = w_grp_wrap;
    assign w_sync_a   = w_grp_last &&
                        ((phr_q == c_PHR_W'(PHR_PER_GRP - 15)) || (phr_q == c_PHR_W'(PHR_PER_GRP - 7)) ||
                         (phr_q == c_PHR_W'(PHR_PER_GRP - 5))  || (phr_q == c_PHR_W'(PHR_PER_GRP - 1)));
    assign w_sync_b   = !w_grp_last &&
                        ((phr_q == c_PHR_W'(PHR_PER_GRP - 13)) || (phr_q == c_PHR_W'(PHR_PER_GRP - 11)) ||
                         (phr_q == c_PHR_W'(PHR_PER_GRP - 9))  || (phr_q == c_PHR_W'(PHR_PER_GRP - 3)));
    assign w_sync_c   = (ccl_q == '0) && (grp_q == '0) && (phr_q == c_PHR_W'(15));
    assign w_frame_sync = w_sync_a || w_sync_b || w_sync_c;

    assign w_marker = (wrd_q != '0) ? 2'b00 :
                      w_frame_sync  ? 2'b11 :
                      phr_q[0]      ? 2'b00 : 2'b10;

    assign w_sym_bit = shreg_q[DATA_W-1] ^ (mode_q & sym_q[0]);
    assign w_serial  = w_sym_bit |
                       ((sym_q == '0) & w_marker[1]) |
                       ((sym_q == c_SYM_W'(1)) & w_marker[0]);

    always_comb begin
        phase_d  = w_phase_end ? '0 : phase_q + 1'b1;
        sym_d    = sym_q;
        shreg_d  = shreg_q;
        mode_d   = mode_q;
        addr_d   = addr_q;
        wrd_d    = wrd_q;
        phr_d    = phr_q;
        grp_d    = grp_q;
        ccl_d    = ccl_q;
        serial_d = serial_q;
        valid_d  = 1'b0;
        par_d    = par_q;
        mark_d   = mark_q;
        phr_o_d  = phr_o_q;
        grp_o_d  = grp_o_q;
        rden_d   = w_rd;
        oaddr_d  = oaddr_q;
        switch_d = switch_q;

        if (w_phase_end) begin
            sym_d = w_last_sym ? '0 : sym_q + 1'b1;
        end

        if (w_load) begin
            shreg_d = iData;
            mode_d  = iMode;
            wrd_d   = w_wrd_wrap ? '0 : wrd_q + 1'b1;
            if (w_wrd_wrap) begin
                phr_d = w_phr_wrap ? '0 : phr_q + 1'b1;
                if (w_phr_wrap) begin
                    grp_d = w_grp_wrap ? '0 : grp_q + 1'b1;
                    if (w_grp_wrap) begin
                        ccl_d = w_ccl_wrap_pos ? '0 : ccl_q + 1'b1;
                    end
                end
            end
            // oaddr_q still holds the address of the read being loaded now
            if (oaddr_q == '0) begin
                switch_d = ~switch_q;
            end
        end else if (w_phase_end && sym_q[0]) begin
            shreg_d = shreg_q << 1;
        end

        if (w_sym_start) begin
            serial_d = w_serial;
            if (sym_q == '0) begin
                valid_d = 1'b1;
                par_d   = shreg_q;
                mark_d  = w_marker;
                phr_o_d = phr_q;
                grp_o_d = grp_q;
            end
        end

        if (w_rd) begin
            oaddr_d = addr_q;
            addr_d  = addr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q  <= '0;
            sym_q    <= '0;
            shreg_q  <= '0;
            mode_q   <= 1'b0;
            addr_q   <= '0;
            wrd_q    <= '0;
            phr_q    <= '0;
            grp_q    <= '0;
            ccl_q    <= '0;
            serial_q <= 1'b0;
            valid_q  <= 1'b0;
            par_q    <= '0;
            mark_q   <= 2'b00;
            phr_o_q  <= '0;
            grp_o_q  <= '0;
            rden_q   <= 1'b0;
            oaddr_q  <= '0;
            switch_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            sym_q    <= sym_d;
            shreg_q  <= shreg_d;
            mode_q   <= mode_d;
            addr_q   <= addr_d;
            wrd_q    <= wrd_d;
            phr_q    <= phr_d;
            grp_q    <= grp_d;
            ccl_q    <= ccl_d;
            serial_q <= serial_d;
            valid_q  <= valid_d;
            par_q    <= par_d;
            mark_q   <= mark_d;
            phr_o_q  <= phr_o_d;
            grp_o_q  <= grp_o_d;
            rden_q   <= rden_d;
            oaddr_q  <= oaddr_d;
            switch_q <= switch_d;
        end
    end

`ifdef M_SEC_COUNTER_EN
    logic [15:0] sec_q, sec_d;
    logic        w_sec_inc;

    assign w_sec_inc = w_load && w_wrd_wrap && w_phr_wrap && w_grp_wrap && w_ccl_wrap_pos;

    // Four-digit BCD increment; 9999 rolls over to 0000
    always_comb begin
        logic v_carry;
        sec_d   = sec_q;
        v_carry = w_sec_inc;
        for (int i = 0; i < 4; i++) begin
            if (v_carry) begin
                if (sec_q[4*i +: 4] == 4'd9) begin
                    sec_d[4*i +: 4] = 4'd0;
                end else begin
                    sec_d[4*i +: 4] = sec_q[4*i +: 4] + 4'd1;
                    v_carry         = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sec_q <= '0;
        end else begin
            sec_q <= sec_d;
        end
    end

    assign oSec = sec_q;
`else
    assign oSec = 16'h0000;
`endif

    assign oRdEn     = rden_q;
    assign oAddr     = oaddr_q;
    assign oSwitch   = switch_q;
    assign oSerial   = serial_q;
    assign oParallel = par_q;
    assign oValid    = valid_q;
    assign oMarker   = mark_q;
    assign oPhr      = phr_o_q;
    assign oGrp      = grp_o_q;

endmodule
`default_nettype wire

// File: tb/tb_m_frame_serializer.sv
`default_nettype none
// Scoreboard bench for m_frame_serializer using a reduced frame geometry
// (2 words/phrase, 32 phrases/group, 2 groups/cycle, 2 cycles/frame, 32-word memory).
module tb_m_frame_serializer;

    localparam int DATA_W    = 12;
    localparam int ADDR_W    = 5;
    localparam int BIT_DIV   = 4;
    localparam int WPP       = 2;
    localparam int PPG       = 32;
    localparam int GPC       = 2;
    localparam int CPF       = 2;
    localparam int NSYM      = 2 * DATA_W;
    localparam int WORD_CLK  = NSYM * BIT_DIV;
    localparam int MEM_N     = 1 << ADDR_W;
    localparam int FRM_WORDS = WPP * PPG * GPC * CPF;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              iMode = 1'b0;
    logic [DATA_W-1:0] iData = '0;
    logic              oRdEn;
    logic [ADDR_W-1:0] oAddr;
    logic              oSwitch;
    logic              oSerial;
    logic [DATA_W-1:0] oParallel;
    logic              oValid;
    logic [1:0]        oMarker;
    logic [4:0]        oPhr;
    logic [0:0]        oGrp;
    logic [15:0]       oSec;

    m_frame_serializer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BIT_DIV(BIT_DIV), .WRD_PER_PHR(WPP),
        .PHR_PER_GRP(PPG), .GRP_PER_CCL(GPC), .CCL_PER_FRM(CPF)
    ) dut (
        .clk(clk), .reset(reset), .iData(iData), .iMode(iMode),
        .oRdEn(oRdEn), .oAddr(oAddr), .oSwitch(oSwitch), .oSerial(oSerial),
        .oParallel(oParallel), .oValid(oValid), .oMarker(oMarker),
        .oPhr(oPhr), .oGrp(oGrp), .oSec(oSec)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int          slot;
        logic [11:0] data;
        logic [1:0]  mark;
        logic [4:0]  phr;
        logic [0:0]  grp;
        logic        sw;
        logic [15:0] sec;
        logic [23:0] syms;
    } exp_t;

    exp_t        q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [11:0] mem [MEM_N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic logic [1:0] exp_marker(int w, int p, int g, int c);
        if (w != 0) return 2'b00;
        if (g == GPC-1 && (p == PPG-15 || p == PPG-7 || p == PPG-5 || p == PPG-1)) return 2'b11;
        if (g != GPC-1 && (p == PPG-13 || p == PPG-11 || p == PPG-9 || p == PPG-3)) return 2'b11;
        if (c == 0 && g == 0 && p == 15) return 2'b11;
        return (p % 2 == 0) ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [15:0] to_bcd(int v);
        logic [15:0] r;
        r = {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
        return r;
    endfunction

    function automatic exp_t make_exp(int n, logic mode);
        exp_t e;
        int   w, p, g, c;
        logic m, b, sy;
        w = n % WPP;
        p = (n / WPP) % PPG;
        g = (n / (WPP * PPG)) % GPC;
        c = (n / (WPP * PPG * GPC)) % CPF;
        e.slot = n;
        e.data = (n == 0) ? 12'h000 : mem[(n - 1) % MEM_N];
        m      = (n == 0) ? 1'b0 : mode;
        e.mark = exp_marker(w, p, g, c);
        e.phr  = 5'(p);
        e.grp  = 1'(g);
        e.sw   = (n == 0) ? 1'b0 : 1'(((n - 1) / MEM_N + 1) % 2);
`ifdef M_SEC_COUNTER_EN
        e.sec  = to_bcd(n / FRM_WORDS);
`else
        e.sec  = 16'h0000;
`endif
        for (int s = 0; s < NSYM; s++) begin
            b  = e.data[DATA_W - 1 - s / 2];
            sy = (s % 2 == 1 && m) ? ~b : b;
            if (s == 0) sy = sy | e.mark[1];
            if (s == 1) sy = sy | e.mark[0];
            e.syms[NSYM - 1 - s] = sy;
        end
        return e;
    endfunction

    // Pulses reset for one clock, checks the cleared outputs and queues the expected slots
    task automatic start_run(input logic mode, input int nw, input bit drain);
        exp_t e;
        @(negedge clk);
        if (drain) check("queue_drained", 64'(q.size()), 64'd0);
        reset = 1'b1;
        iMode = mode;
        @(posedge clk); #1;
        check("reset_outputs",
              {oRdEn, oAddr, oSwitch, oSerial, oParallel, oValid, oMarker, oPhr, oGrp, oSec}, 64'd0);
        q.delete();
        for (int n = 0; n < nw; n++) begin
            e = make_exp(n, mode);
            if (n == 0) e.syms = 24'h800000;
            if (n == 1) e.syms = mode ? 24'b1001_1001_0110_0110_1010_0101
                                      : 24'b1100_1100_0011_0011_1111_0000;
            q.push_back(e);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin : mem_model
        logic [ADDR_W-1:0] a;
        forever begin
            @(posedge clk); #1;
            if (oRdEn) begin
                a     = oAddr;
                iData = ~mem[a];
                @(posedge clk); #1;
                iData = mem[a];
            end
        end
    end

    initial begin : word_monitor
        exp_t        e;
        logic [23:0] got;
        logic [36:0] fields;
        bit          aborted, extra, have;
        forever begin
            @(posedge clk); #1;
            if (!reset && oValid) begin
                have = (q.size() != 0);
                if (!have) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_word: got oParallel %h, expected no word", oParallel);
                end else begin
                    e = q.pop_front();
                    fields = {oParallel, oMarker, oPhr, oGrp, oSwitch, oSec};
                    check($sformatf("slot%0d_fields", e.slot), 64'(fields),
                          64'({e.data, e.mark, e.phr, e.grp, e.sw, e.sec}));
                end
                got     = '0;
                got[23] = oSerial;
                aborted = 1'b0;
                extra   = 1'b0;
                for (int c = 1; c <= (NSYM - 1) * BIT_DIV; c++) begin
                    @(posedge clk); #1;
                    if (reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (oValid) extra = 1'b1;
                    if (c % BIT_DIV == 0) got[NSYM - 1 - c / BIT_DIV] = oSerial;
                end
                if (have && !aborted) begin
                    check($sformatf("slot%0d_symbols", e.slot), 64'(got), 64'(e.syms));
                    check($sformatf("slot%0d_valid_pulse", e.slot), 64'(extra), 64'd0);
                end
            end
        end
    end

    initial begin : rd_monitor
        int t;
        int ea;
        t  = 0;
        ea = 0;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                t  = 0;
                ea = 0;
            end else begin
                if (oRdEn) begin
                    check($sformatf("rd_strobe_t%0d", t),
                          64'({t % WORD_CLK, 32'(oAddr)}),
                          64'({(NSYM - 1) * BIT_DIV, ea}));
                    ea = (ea + 1) % MEM_N;
                end
                t++;
            end
        end
    end

    initial begin : stimulus
        for (int a = 0; a < MEM_N; a++) mem[a] = 12'((a * 12'h1D3 + 12'h2E1) & 12'hFFF);
        mem[0] = 12'hA5C;
        repeat (3) @(negedge clk);

        // Long bit-doubled run: address wraps, switch toggles, both groups and cycles
        start_run(1'b0, 162, 1'b0);
        repeat (162 * WORD_CLK - 2) @(negedge clk);

        // Manchester run
        start_run(1'b1, 4, 1'b1);
        repeat (4 * WORD_CLK - 2) @(negedge clk);

        // Reset at clock 50 of slot 1, then the stream restarts as slot 0
        start_run(1'b0, 4, 1'b1);
        repeat (WORD_CLK + 50 - 1) @(negedge clk);
        start_run(1'b0, 4, 1'b0);
        repeat (4 * WORD_CLK - 2) @(negedge clk);

        @(negedge clk);
        check("queue_drained", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
